// File: rtl/symbol_seq_detector.sv
// rtl/symbol_seq_detector.sv - overlap-aware 4-symbol sequence detector with saturating match/toggle counters
module symbol_seq_detector #(
    parameter logic [1:0] P0 = 2'd3,
    parameter logic [1:0] P1 = 2'd0,
    parameter logic [1:0] P2 = 2'd1,
    parameter logic [1:0] P3 = 2'd2,
    parameter int         CW = 8,
    parameter int         TW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    data,
    input  logic          enable,
    input  logic          clear,
    output logic          dummy,
    output logic [CW-1:0] match_count,
    output logic [TW-1:0] toggle_count,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    localparam logic [1:0] PAT [4] = '{P0, P1, P2, P3};

    // Longest suffix (capped at lim) of (first n pattern symbols + s) that is also a pattern prefix.
    function automatic logic [2:0] suffix_len(input int n, input logic [1:0] s, input int lim);
        logic [2:0] best;
        logic       ok;
        logic [1:0] sym;
        int         idx;
        best = 3'd0;
        for (int l = 1; l <= 4; l++) begin
            if (l <= n + 1 && l <= lim) begin
                ok = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    if (j < l) begin
                        idx = n + 1 - l + j;
                        sym = (idx == n) ? s : PAT[idx[1:0]];
                        if (sym != PAT[j[1:0]]) ok = 1'b0;
                    end
                end
                if (ok) best = 3'(l);
            end
        end
        return best;
    endfunction

    localparam logic [2:0] FB_DETECT = suffix_len(3, P3, 3);

    state_t        state_q, state_d;
    logic          dummy_q, dummy_d;
    logic [CW-1:0] match_q, match_d;
    logic [TW-1:0] toggle_q, toggle_d;
    logic [1:0]    prev_q, prev_d;

    logic [2:0]    depth;
    logic [1:0]    flips;
    logic [1:0]    pop;
    logic [TW:0]   tsum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S0;
            dummy_q  <= 1'b0;
            match_q  <= '0;
            toggle_q <= '0;
            prev_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            dummy_q  <= dummy_d;
            match_q  <= match_d;
            toggle_q <= toggle_d;
            prev_q   <= prev_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dummy_d  = 1'b0;
        match_d  = match_q;
        toggle_d = toggle_q;
        prev_d   = prev_q;
        depth    = suffix_len(int'(state_q), data, 4);
        flips    = data ^ prev_q;
        pop      = {1'b0, flips[1]} + {1'b0, flips[0]};
        tsum     = {1'b0, toggle_q} + (TW+1)'(pop);

        if (clear) begin
            state_d  = S0;
            match_d  = '0;
            toggle_d = '0;
            prev_d   = data;
        end else if (enable) begin
            if (depth == 3'd4) begin
                dummy_d = 1'b1;
                state_d = state_t'(FB_DETECT[1:0]);
                if (match_q != {CW{1'b1}}) match_d = match_q + CW'(1);
            end else begin
                state_d = state_t'(depth[1:0]);
            end
            // Overflow bit of the widened sum selects saturation, covering +2 at all-ones-minus-one.
            toggle_d = tsum[TW] ? {TW{1'b1}} : tsum[TW-1:0];
            prev_d   = data;
        end
    end

    assign dummy        = dummy_q;
    assign match_count  = match_q;
    assign toggle_count = toggle_q;
    assign fsm_state    = state_q;

endmodule

// File: doc/symbol_seq_detector.md
Name: symbol_seq_detector

Overview:
- Receiving end of the 2-bit symbol stream that the gate-level power-characterisation stimulus drives into the design under test.
- Samples `data` on every rising clock edge and detects a programmable 4-symbol sequence, overlap-aware. Default sequence is 3,0,1,2.
- Pulses `dummy` once per detection.
- Keeps a saturating match counter and a saturating bit-toggle counter on `data`. These cross-check SAIF switching activity against RTL-observed activity.

Parameters:
- P0, 3, first symbol of the target sequence (2 bits)
- P1, 0, second symbol
- P2, 1, third symbol
- P3, 2, fourth symbol
- CW, 8, width of `match_count`
- TW, 16, width of `toggle_count`

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- data  input  2  symbol stream, sampled at rising edge
- enable  input  1  when 1, the current edge consumes a symbol; when 0, all state holds
- clear  input  1  synchronous clear of FSM, counters and `dummy`
- dummy  output  1  registered one-cycle detection pulse
- match_count  output  CW  number of detections, saturating
- toggle_count  output  TW  cumulative bit flips on `data`, saturating
- fsm_state  output  2  current match depth 0..3, for debug

Behaviour:
- Reset (`reset`=0, asynchronous, overrides everything):
  - FSM to S0.
  - `dummy`=0, `match_count`=0, `toggle_count`=0.
  - Internal `prev_data`=0.
  - Outputs change immediately, not at the next edge.
- Edge priority:
  - `clear`=1: same effect as reset except `prev_data` loads the current `data`. `enable` is ignored.
  - Else `enable`=0: FSM, counters and `prev_data` hold; `dummy` goes 0.
  - Else (`enable`=1): normal operation, below.
- FSM states (state = matched prefix length):
  - S0: nothing matched.
  - S1: P0 seen.
  - S2: P0,P1 seen.
  - S3: P0,P1,P2 seen.
- Transitions:
  - In Sk, if the symbol equals P(k): go to S(k+1). From S3, a match instead goes to the fallback state and asserts detection.
  - On mismatch, or after a detection: next state = the longest proper suffix of (matched prefix + new symbol) that is also a prefix of the pattern.
  - The fallback is computed combinationally from the parameters and must be correct for any P0..P3, including self-overlapping patterns such as 1,1,1,1.
  - For the default pattern: a mismatch in S1/S2/S3 goes to S1 if the symbol is 3, else S0. After a detection the FSM goes to S0.
- `dummy`:
  - Registered. It is 1 for exactly the one cycle after the edge that samples the completing symbol.
  - Back-to-back detections (overlapping pattern) give consecutive high cycles.
- `match_count`: increments by 1 on every detection edge; holds at 2^CW−1.
- `toggle_count`:
  - On each enabled edge, adds popcount(`data` XOR `prev_data`), which is 0, 1 or 2.
  - The sum saturates at 2^TW−1; it never wraps, including when adding 2 at all-ones−1.
  - `prev_data` <= `data` on the same edge.
- Latency: symbol sampled at edge N → `dummy` and `match_count` update visible after edge N.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold `reset`=0 with `data`=3 and clock running → `dummy`=0, `match_count`=0, `toggle_count`=0, `fsm_state`=0 throughout.
- Basic detection: `enable`=1, feed 3,0,1,2 one per cycle → `fsm_state` steps 1,2,3,0. `dummy`=1 for one cycle after the edge sampling 2. `match_count`=1. `toggle_count`=7 (2+2+1+2).
- Fallback: feed 3,3,0,1,2 → one detection. Feed 3,0,3,0,1,2 → one detection; `fsm_state` goes back to 1 at the third symbol.
- Enable gating and clear:
  - Feed 3,0, then hold `enable`=0 with `data`=2 for 3 cycles, then 1,2 → one detection; `toggle_count` excludes the gated cycles.
  - `clear`=1 for one cycle → all counts 0.
- Saturation: CW=2 with 5 sequences → `match_count` stops at 3 while `dummy` still pulses 5 times. TW=3 with alternating 0/3 → `toggle_count` stops at 7.
- Async reset mid-sequence: after 3,0,1, drop `reset` between edges → outputs clear immediately. Release, feed 2 → no detection.
